c2_capture_skid: RTL and testbench

Registered, handshaked capture stage that sits directly downstream of the C2 combinational selector. It samples C2's SIZE-bit `out` word together with the 2-bit select code that produced it. It holds the pair in a 2-entry skid buffer so the consumer can apply back-pressure without losing data. It also keeps a saturating count of accepted words, for observability.

---
 rtl/c2_pkg.sv | 14 +
 rtl/c2_capture_skid_sat_counter.sv | 15 +
 rtl/c2_capture_skid.sv | 89 ++++++++
 tb/tb_c2_capture_skid.sv | 131 +++++++++++++
 4 files changed

// File: rtl/c2_pkg.sv
// Shared definitions for the C2 selector datapath and its capture stage.
package c2_pkg;
  localparam int SIZE = 5;

  localparam logic [1:0] SEL_D00 = 2'd0;
  localparam logic [1:0] SEL_D01 = 2'd1;
  localparam logic [1:0] SEL_D10 = 2'd2;
  localparam logic [1:0] SEL_D11 = 2'd3;

  // A buffered entry is {data, sel}.
  function automatic int entry_w(input int size);
    return size + 2;
  endfunction
endpackage

// File: rtl/c2_capture_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr)        q <= '0;
    else if (inc && ~&q)   q <= q + 1'b1;
  end
endmodule

// File: rtl/c2_capture_skid.sv
// Two-entry skid capture stage for the C2 selector output plus accept counter.
module c2_capture_skid
  import c2_pkg::*;
#(
  parameter int SIZE  = c2_pkg::SIZE,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  input  logic [1:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic [1:0]       out_sel,
  output logic [CNT_W-1:0] count
);
  localparam int EW = entry_w(SIZE);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e        state;
  logic [EW-1:0] main_q, skid_q, in_ent;
  logic          accept, pop;

  assign in_ent = {in_data, in_sel};
  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // in_ready/out_valid are registered alongside the state so neither
  // output has a combinational path from the other side's handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (clr) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q    <= in_ent;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_ent;
          end else if (accept) begin
            skid_q   <= in_ent;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: if (pop) begin
          main_q   <= skid_q;
          in_ready <= 1'b1;
          state    <= ONE;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data = main_q[EW-1:2];
  assign out_sel  = main_q[1:0];

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept),
    .q   (count)
  );
endmodule

// File: tb/tb_c2_capture_skid.sv
// Randomized/directed bench for c2_capture_skid against a queue-based model.
module tb_c2_capture_skid;
  import c2_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [4:0] in_data;
  logic [1:0] in_sel;
  logic       in_ready, out_valid, in_ready3, out_valid3;
  logic [4:0] out_data, out_data3;
  logic [1:0] out_sel, out_sel3;
  logic [7:0] count;
  logic [2:0] count3;

  int checks = 0, errors = 0;
  int mcnt = 0;
  logic [6:0] mq[$];

  always #5 clk = ~clk;

  c2_capture_skid #(.SIZE(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .count(count)
  );

  c2_capture_skid #(.SIZE(5), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_sel(out_sel3),
    .count(count3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model before the
  // edge, then advance the model with what the edge will do.
  task automatic cycle(input logic v, input logic [4:0] d, input logic [1:0] s,
                       input logic r, input logic c);
    logic [6:0] head;
    logic acc, pp;
    in_valid = v; in_data = d; in_sel = s; out_ready = r; clr = c;
    @(negedge clk);
    chk("in_ready",  in_ready,  mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready3", in_ready3, mq.size() < 2);
    chk("count",     count,  (mcnt > 255) ? 255 : mcnt);
    chk("count3",    count3, (mcnt > 7)   ? 7   : mcnt);
    if (mq.size() > 0) begin
      head = mq[0];
      chk("out_data", out_data, head[6:2]);
      chk("out_sel",  out_sel,  head[1:0]);
    end
    acc = v && (mq.size() < 2);
    pp  = r && (mq.size() > 0);
    if (c) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({d, s});
        mcnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 5'd21; in_sel = SEL_D11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel",  out_sel,  0);
    chk("rst_count",    count,    0);

    // Streaming with all four select codes.
    cycle(1, 5'd1, SEL_D00, 1, 0);
    cycle(1, 5'd2, SEL_D01, 1, 0);
    cycle(1, 5'd3, SEL_D10, 1, 0);
    cycle(1, 5'd4, SEL_D11, 1, 0);
    cycle(0, 5'd0, SEL_D00, 1, 0);
    chk("stream_count", count, 4);

    // Back-pressure: fill, hold, then drain.
    cycle(1, 5'd9,  2'd0, 0, 0);
    cycle(1, 5'd10, 2'd3, 0, 0);
    cycle(1, 5'd11, 2'd1, 0, 0);
    cycle(0, 5'd0,  2'd0, 0, 0);
    chk("bp_hold_data", out_data, 9);
    chk("bp_ready_low", in_ready, 0);
    cycle(0, 5'd0, 2'd0, 1, 0);
    cycle(0, 5'd0, 2'd0, 1, 0);
    cycle(0, 5'd0, 2'd0, 1, 0);
    chk("bp_ready_back", in_ready, 1);

    // Flush while full with a word offered.
    cycle(1, 5'd5, 2'd2, 0, 0);
    cycle(1, 5'd6, 2'd1, 0, 0);
    cycle(1, 5'd7, 2'd3, 0, 1);
    chk("clr_valid", out_valid, 0);
    chk("clr_ready", in_ready,  1);
    chk("clr_count", count,     0);
    cycle(0, 5'd0, 2'd0, 1, 0);

    // Saturation of the 3-bit counter.
    for (int i = 0; i < 10; i++) cycle(1, 5'(i + 12), 2'(i), 1, 0);
    cycle(0, 5'd0, 2'd0, 1, 0);
    chk("sat_count3", count3, 7);
    chk("sat_count8", count,  10);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom), 2'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
    for (int i = 0; i < 4; i++) cycle(0, 5'd0, 2'd0, 1, 0);
    chk("drain_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
